// File: rtl/freq_meter_1s.sv
// freq_meter_1s: counts synchronized rising edges of sig_in between consecutive
// rising edges of tick_1s and hands the latched count to a reader via valid/ack.
// Optional min/max tracking of latched results is enabled by defining FREQ_MINMAX_EN.
module freq_meter_1s #(
  parameter int unsigned CNT_W       = 26,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  input  logic             tick_1s,
  input  logic             freq_ack,
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic             freq_ovf,
  output logic             overrun,
  output logic             busy
`ifdef FREQ_MINMAX_EN
  ,
  input  logic             minmax_clr,
  output logic [CNT_W-1:0] freq_min,
  output logic [CNT_W-1:0] freq_max
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig_prev_q;
  logic                   tick_prev_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   sat_q;
  logic [CNT_W-1:0]       freq_q;
  logic                   freq_valid_q;
  logic                   freq_ovf_q;
  logic                   overrun_q;
  logic                   busy_q;

  logic                   sig_rise;
  logic                   gate;
  logic                   latch;
  logic [CNT_W-1:0]       cnt_start_d;

  // Edge detects, latch strobe and window start value (coincident edge opens the new window)
  always_comb begin
    sig_rise    = sync_q[SYNC_STAGES-1] & ~sig_prev_q;
    gate        = tick_1s & ~tick_prev_q;
    latch       = en && (state_q == ST_COUNT) && gate;
    cnt_start_d = CNT_W'(sig_rise);
  end

  // Synchronizer for sig_in plus edge-detect history flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      sig_prev_q  <= 1'b0;
      tick_prev_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], sig_in};
      sig_prev_q  <= sync_q[SYNC_STAGES-1];
      tick_prev_q <= tick_1s;
    end
  end

  // Measurement FSM and saturating edge counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else if (!en) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_ARM;
          busy_q  <= 1'b0;
        end
        ST_ARM: begin
          if (gate) begin
            state_q <= ST_COUNT;
            busy_q  <= 1'b1;
            cnt_q   <= cnt_start_d;
            sat_q   <= 1'b0;
          end
        end
        ST_COUNT: begin
          if (gate) begin
            cnt_q <= cnt_start_d;
            sat_q <= 1'b0;
          end else if (sig_rise) begin
            if (cnt_q == CNT_MAX) begin
              sat_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Result latch and valid/ack/overrun handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_q       <= '0;
      freq_valid_q <= 1'b0;
      freq_ovf_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else if (latch) begin
      freq_q       <= cnt_q;
      freq_ovf_q   <= sat_q;
      freq_valid_q <= 1'b1;
      if (freq_valid_q && !freq_ack) begin
        overrun_q <= 1'b1;
      end
    end else if (freq_ack && freq_valid_q) begin
      freq_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end
  end

  assign freq       = freq_q;
  assign freq_valid = freq_valid_q;
  assign freq_ovf   = freq_ovf_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

`ifdef FREQ_MINMAX_EN
  logic [CNT_W-1:0] freq_min_q;
  logic [CNT_W-1:0] freq_max_q;

  // Running min/max of latched results; clear parks them so the next latch loads both
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_min_q <= CNT_MAX;
      freq_max_q <= '0;
    end else if (latch) begin
      if (minmax_clr || (cnt_q < freq_min_q)) begin
        freq_min_q <= cnt_q;
      end
      if (minmax_clr || (cnt_q > freq_max_q)) begin
        freq_max_q <= cnt_q;
      end
    end else if (minmax_clr) begin
      freq_min_q <= CNT_MAX;
      freq_max_q <= '0;
    end
  end

  assign freq_min = freq_min_q;
  assign freq_max = freq_max_q;
`endif

endmodule
